rotate_kick_unit: RTL and testbench

Sequential rotation engine for the active tetromino. It generalises fixed per-orientation rotation to every piece colour, both directions, and a parametrised cell count, coordinate width and board size. Each rotation is tried against a configurable wall-kick list: out-of-board candidates are rejected locally, and in-board candidates are checked against the board through a collision-query handshake. It sits between the game-control FSM, which issues rotate requests, and the board/collision checker; on success it returns the committed cell coordinates and the new orientation.

---
 rtl/rotate_kick_unit.sv | 248 ++++++++++++++++++++++++
 tb/tb_rotate_kick_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_kick_unit.sv
// rotate_kick_unit: sequential tetromino rotation with wall kicks.
// Each rotation candidate is formed around the pivot cell, shifted by one kick
// offset at a time, rejected locally when it leaves the board, and otherwise
// handed to an external collision checker through a valid/response handshake.

package types_pkg;

   typedef enum logic [2:0] {
      CYAN,
      YELLOW,
      MAGENTA,
      GREEN,
      RED,
      BLUE,
      ORANGE
   } block_color;

   typedef enum logic [1:0] {
      NORMAL,
      ROT_LEFT,
      ROT2,
      ROT_RIGHT
   } orientation;

endpackage

module rotate_kick_unit
   import types_pkg::*;
#(
   parameter int COORD_W   = 5,
   parameter int NUM_CELLS = 4,
   parameter int NUM_KICKS = 5,
   parameter int BOARD_W   = 10,
   parameter int BOARD_H   = 20
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           rotate_left,
   input  block_color                     block,
   input  orientation                     cur_orientation,
   input  logic [NUM_CELLS*COORD_W-1:0]   x_block,
   input  logic [NUM_CELLS*COORD_W-1:0]   y_block,
   output logic                           query_valid,
   output logic [NUM_CELLS*COORD_W-1:0]   query_x,
   output logic [NUM_CELLS*COORD_W-1:0]   query_y,
   input  logic                           resp_valid,
   input  logic                           resp_collide,
   output logic                           busy,
   output logic                           done,
   output logic                           success,
   output logic [NUM_CELLS*COORD_W-1:0]   new_x,
   output logic [NUM_CELLS*COORD_W-1:0]   new_y,
   output orientation                     new_orientation
);

   // Two extra bits give headroom for negative offsets and for kicks past the edge.
   localparam int SW = COORD_W + 2;
   localparam int XW = NUM_CELLS * COORD_W;

   localparam logic signed [SW-1:0] BOARD_W_S = SW'(BOARD_W);
   localparam logic signed [SW-1:0] BOARD_H_S = SW'(BOARD_H);
   localparam logic [2:0]           LAST_KICK = 3'(NUM_KICKS - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      QUERY,
      DONE
   } state_t;

   state_t     state;
   logic [2:0] kick_idx;
   logic       lat_left;
   orientation lat_orient;
   logic [XW-1:0] lat_x;
   logic [XW-1:0] lat_y;

   logic [XW-1:0] cand_x;
   logic [XW-1:0] cand_y;
   logic          cand_oob;

   // Clockwise kick table; counter-clockwise mirrors the horizontal component.
   function automatic logic signed [SW-1:0] kick_dx(input logic [2:0] k);
      case (k)
         3'd1:    kick_dx = SW'(-1);
         3'd2:    kick_dx = SW'(1);
         3'd4:    kick_dx = SW'(-2);
         default: kick_dx = '0;
      endcase
   endfunction

   function automatic logic signed [SW-1:0] kick_dy(input logic [2:0] k);
      case (k)
         3'd3:    kick_dy = SW'(-1);
         default: kick_dy = '0;
      endcase
   endfunction

   // Counter-clockwise walks NORMAL->ROT_LEFT->ROT2->ROT_RIGHT, clockwise the other way.
   function automatic orientation step_orientation(input orientation o, input logic ccw);
      case (o)
         NORMAL:    step_orientation = ccw ? ROT_LEFT  : ROT_RIGHT;
         ROT_LEFT:  step_orientation = ccw ? ROT2      : NORMAL;
         ROT2:      step_orientation = ccw ? ROT_RIGHT : ROT_LEFT;
         default:   step_orientation = ccw ? NORMAL    : ROT2;
      endcase
   endfunction

   // Build the candidate for the current kick and flag any cell that leaves the board.
   always_comb begin
      logic signed [SW-1:0] pivot_x;
      logic signed [SW-1:0] pivot_y;
      logic signed [SW-1:0] kick_x;
      logic signed [SW-1:0] kick_y;
      logic signed [SW-1:0] off_x;
      logic signed [SW-1:0] off_y;
      logic signed [SW-1:0] rot_x;
      logic signed [SW-1:0] rot_y;
      logic signed [SW-1:0] pos_x;
      logic signed [SW-1:0] pos_y;

      cand_x   = '0;
      cand_y   = '0;
      cand_oob = 1'b0;
      pivot_x  = $signed({2'b00, lat_x[COORD_W +: COORD_W]});
      pivot_y  = $signed({2'b00, lat_y[COORD_W +: COORD_W]});
      kick_x   = lat_left ? -kick_dx(kick_idx) : kick_dx(kick_idx);
      kick_y   = kick_dy(kick_idx);
      off_x    = '0;
      off_y    = '0;
      rot_x    = '0;
      rot_y    = '0;
      pos_x    = '0;
      pos_y    = '0;

      for (int i = 0; i < NUM_CELLS; i++) begin
         off_x = $signed({2'b00, lat_x[i*COORD_W +: COORD_W]}) - pivot_x;
         off_y = $signed({2'b00, lat_y[i*COORD_W +: COORD_W]}) - pivot_y;
         rot_x = lat_left ? off_y : -off_y;
         rot_y = lat_left ? -off_x : off_x;
         pos_x = pivot_x + rot_x + kick_x;
         pos_y = pivot_y + rot_y + kick_y;
         if (pos_x[SW-1] || (pos_x >= BOARD_W_S) || pos_y[SW-1] || (pos_y >= BOARD_H_S)) begin
            cand_oob = 1'b1;
         end
         cand_x[i*COORD_W +: COORD_W] = pos_x[COORD_W-1:0];
         cand_y[i*COORD_W +: COORD_W] = pos_y[COORD_W-1:0];
      end
   end

   // Control FSM: latch the request, walk the kick list, and register every output.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         kick_idx        <= '0;
         lat_left        <= 1'b0;
         lat_orient      <= NORMAL;
         lat_x           <= '0;
         lat_y           <= '0;
         query_valid     <= 1'b0;
         query_x         <= '0;
         query_y         <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         success         <= 1'b0;
         new_x           <= '0;
         new_y           <= '0;
         new_orientation <= NORMAL;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  lat_left   <= rotate_left;
                  lat_orient <= cur_orientation;
                  lat_x      <= x_block;
                  lat_y      <= y_block;
                  kick_idx   <= '0;
                  busy       <= 1'b1;
                  if (block == YELLOW) begin
                     state           <= DONE;
                     done            <= 1'b1;
                     success         <= 1'b1;
                     new_x           <= x_block;
                     new_y           <= y_block;
                     new_orientation <= cur_orientation;
                  end else begin
                     state <= CALC;
                  end
               end
            end

            CALC: begin
               if (!cand_oob) begin
                  query_x     <= cand_x;
                  query_y     <= cand_y;
                  query_valid <= 1'b1;
                  state       <= QUERY;
               end else if (kick_idx == LAST_KICK) begin
                  state           <= DONE;
                  done            <= 1'b1;
                  success         <= 1'b0;
                  new_x           <= lat_x;
                  new_y           <= lat_y;
                  new_orientation <= lat_orient;
               end else begin
                  kick_idx <= kick_idx + 3'd1;
               end
            end

            QUERY: begin
               if (resp_valid) begin
                  query_valid <= 1'b0;
                  if (!resp_collide) begin
                     state           <= DONE;
                     done            <= 1'b1;
                     success         <= 1'b1;
                     new_x           <= query_x;
                     new_y           <= query_y;
                     new_orientation <= step_orientation(lat_orient, lat_left);
                  end else if (kick_idx == LAST_KICK) begin
                     state           <= DONE;
                     done            <= 1'b1;
                     success         <= 1'b0;
                     new_x           <= lat_x;
                     new_y           <= lat_y;
                     new_orientation <= lat_orient;
                  end else begin
                     kick_idx <= kick_idx + 3'd1;
                     state    <= CALC;
                  end
               end
            end

            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rotate_kick_unit.sv
// tb_rotate_kick_unit: directed bench with a behavioural collision checker and
// queue-based scoreboards for both the expected queries and the expected results.

module tb_rotate_kick_unit;
   import types_pkg::*;

   localparam int CW = 5;
   localparam int NC = 4;
   localparam int NK = 5;
   localparam int BW = 10;
   localparam int BH = 20;
   localparam int XW = NC * CW;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          rotate_left;
   block_color    block;
   orientation    cur_orientation;
   logic [XW-1:0] x_block;
   logic [XW-1:0] y_block;
   logic          query_valid;
   logic [XW-1:0] query_x;
   logic [XW-1:0] query_y;
   logic          resp_valid = 1'b0;
   logic          resp_collide = 1'b0;
   logic          busy;
   logic          done;
   logic          success;
   logic [XW-1:0] new_x;
   logic [XW-1:0] new_y;
   orientation    new_orientation;

   typedef struct {
      logic [XW-1:0] qx;
      logic [XW-1:0] qy;
   } query_t;

   typedef struct {
      logic          ok;
      logic [XW-1:0] nx;
      logic [XW-1:0] ny;
      orientation    orient;
   } result_t;

   query_t  expQueryQ[$];
   result_t expResultQ[$];

   int            errors = 0;
   int            checks = 0;
   int            respDelay = 0;
   logic [NK-1:0] collideMask = '0;
   int            queryIdx = 0;
   int            waitCnt = 0;
   int            doneCount = 0;
   logic [XW-1:0] heldX;
   logic [XW-1:0] heldY;

   rotate_kick_unit #(
      .COORD_W   (CW),
      .NUM_CELLS (NC),
      .NUM_KICKS (NK),
      .BOARD_W   (BW),
      .BOARD_H   (BH)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .rotate_left     (rotate_left),
      .block           (block),
      .cur_orientation (cur_orientation),
      .x_block         (x_block),
      .y_block         (y_block),
      .query_valid     (query_valid),
      .query_x         (query_x),
      .query_y         (query_y),
      .resp_valid      (resp_valid),
      .resp_collide    (resp_collide),
      .busy            (busy),
      .done            (done),
      .success         (success),
      .new_x           (new_x),
      .new_y           (new_y),
      .new_orientation (new_orientation)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [XW-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
      logic [XW-1:0] r;
      r[0*CW +: CW] = c0[CW-1:0];
      r[1*CW +: CW] = c1[CW-1:0];
      r[2*CW +: CW] = c2[CW-1:0];
      r[3*CW +: CW] = c3[CW-1:0];
      return r;
   endfunction

   function automatic orientation nextOrient(input orientation o, input logic ccw);
      orientation ccwTab[4];
      orientation cwTab[4];
      ccwTab = '{ROT_LEFT, ROT2, ROT_RIGHT, NORMAL};
      cwTab  = '{ROT_RIGHT, NORMAL, ROT_LEFT, ROT2};
      return ccw ? ccwTab[int'(o)] : cwTab[int'(o)];
   endfunction

   // Reference model: pushes every query the checker should see, the final result,
   // and returns the expected start-to-done latency in clock edges.
   task automatic modelRotate(input block_color color, input logic ccw, input orientation orient,
                              input logic [XW-1:0] xs, input logic [XW-1:0] ys,
                              input logic [NK-1:0] mask, input int delay,
                              output int latency, output int nQueries);
      int kickX[NK];
      int kickY[NK];
      int px, py, dx, dy, cx, cy;
      logic oob;
      query_t q;
      result_t r;
      kickX = '{0, -1, 1, 0, -2};
      kickY = '{0, 0, 0, -1, 0};
      r.ok = 1'b0;
      r.nx = xs;
      r.ny = ys;
      r.orient = orient;
      latency = 1;
      nQueries = 0;
      if (color == YELLOW) begin
         r.ok = 1'b1;
      end else begin
         px = int'(xs[CW +: CW]);
         py = int'(ys[CW +: CW]);
         for (int k = 0; k < NK; k++) begin
            oob = 1'b0;
            latency++;
            for (int i = 0; i < NC; i++) begin
               dx = int'(xs[i*CW +: CW]) - px;
               dy = int'(ys[i*CW +: CW]) - py;
               cx = ccw ? (px + dy - kickX[k]) : (px - dy + kickX[k]);
               cy = ccw ? (py - dx + kickY[k]) : (py + dx + kickY[k]);
               if (cx < 0 || cx >= BW || cy < 0 || cy >= BH) oob = 1'b1;
               q.qx[i*CW +: CW] = cx[CW-1:0];
               q.qy[i*CW +: CW] = cy[CW-1:0];
            end
            if (!oob) begin
               expQueryQ.push_back(q);
               latency += delay + 1;
               nQueries++;
               if (!mask[nQueries-1]) begin
                  r.ok = 1'b1;
                  r.nx = q.qx;
                  r.ny = q.qy;
                  r.orient = nextOrient(orient, ccw);
                  break;
               end
            end
         end
      end
      expResultQ.push_back(r);
   endtask

   // Collision checker: answers each query after respDelay cycles and checks that
   // the presented candidate matches the model and stays stable while waiting.
   always @(negedge clk) begin
      if (reset || !query_valid) begin
         resp_valid   = 1'b0;
         resp_collide = 1'b0;
         waitCnt      = 0;
      end else begin
         if (waitCnt == 0) begin
            heldX = query_x;
            heldY = query_y;
         end else begin
            checkOutput("query_x stable", query_x, heldX);
            checkOutput("query_y stable", query_y, heldY);
         end
         if (waitCnt >= respDelay) begin
            resp_valid   = 1'b1;
            resp_collide = (queryIdx < NK) ? collideMask[queryIdx] : 1'b0;
            checks++;
            assert (expQueryQ.size() != 0)
            else begin
               errors++;
               $error("[TB] FAIL unexpected query: observed x=%0h y=%0h expected none", query_x, query_y);
            end
            if (expQueryQ.size() != 0) begin
               query_t q;
               q = expQueryQ.pop_front();
               checkOutput("query_x", query_x, q.qx);
               checkOutput("query_y", query_y, q.qy);
            end
            queryIdx++;
            waitCnt = 0;
         end else begin
            resp_valid = 1'b0;
            waitCnt++;
         end
      end
   end

   // Count every done pulse so stray completions are visible.
   always @(negedge clk) begin
      if (done) doneCount++;
   end

   task automatic applyStimulus(input string name, input block_color color, input logic ccw,
                                input orientation orient, input logic [XW-1:0] xs,
                                input logic [XW-1:0] ys, input logic [NK-1:0] mask,
                                input int delay, input logic pulseWhileBusy);
      int expLat, expQueries, cycles;
      result_t r;
      modelRotate(color, ccw, orient, xs, ys, mask, delay, expLat, expQueries);
      respDelay   = delay;
      collideMask = mask;
      queryIdx    = 0;
      @(negedge clk);
      block           = color;
      rotate_left     = ccw;
      cur_orientation = orient;
      x_block         = xs;
      y_block         = ys;
      start           = 1'b1;
      cycles          = 0;
      do begin
         @(posedge clk);
         #1;
         start = 1'b0;
         cycles++;
         checkOutput({name, " busy"}, busy, 1'b1);
         if (pulseWhileBusy && cycles == 2) start = 1'b1;
      end while (!done && cycles < 300);
      checkOutput({name, " done seen"}, done, 1'b1);
      checkOutput({name, " latency"}, cycles, expLat);
      if (done && expResultQ.size() != 0) begin
         r = expResultQ.pop_front();
         checkOutput({name, " success"}, success, r.ok);
         checkOutput({name, " new_x"}, new_x, r.nx);
         checkOutput({name, " new_y"}, new_y, r.ny);
         checkOutput({name, " new_orientation"}, new_orientation, r.orient);
      end
      checkOutput({name, " query count"}, queryIdx, expQueries);
      checkOutput({name, " queries left"}, expQueryQ.size(), 0);
      @(posedge clk);
      #1;
      checkOutput({name, " done pulse width"}, done, 1'b0);
      checkOutput({name, " busy after done"}, busy, 1'b0);
   endtask

   task automatic checkResetValues(input string name);
      checkOutput({name, " busy"}, busy, 1'b0);
      checkOutput({name, " done"}, done, 1'b0);
      checkOutput({name, " success"}, success, 1'b0);
      checkOutput({name, " query_valid"}, query_valid, 1'b0);
      checkOutput({name, " query_x"}, query_x, '0);
      checkOutput({name, " query_y"}, query_y, '0);
      checkOutput({name, " new_x"}, new_x, '0);
      checkOutput({name, " new_y"}, new_y, '0);
      checkOutput({name, " new_orientation"}, new_orientation, NORMAL);
   endtask

   // Bound the whole run so a stuck design still reports.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int doneBefore;
      int waited;
      reset           = 1'b1;
      start           = 1'b0;
      rotate_left     = 1'b0;
      block           = CYAN;
      cur_orientation = NORMAL;
      x_block         = '0;
      y_block         = '0;
      repeat (3) @(posedge clk);
      #1;
      checkResetValues("reset");
      reset = 1'b0;

      applyStimulus("t_cw", MAGENTA, 1'b0, NORMAL, pack4(4, 5, 6, 5), pack4(1, 1, 1, 0), 5'b00000, 0, 1'b0);
      checkOutput("t_cw const new_x", new_x, pack4(5, 5, 5, 6));
      checkOutput("t_cw const new_y", new_y, pack4(0, 1, 2, 1));
      checkOutput("t_cw const orient", new_orientation, ROT_RIGHT);

      applyStimulus("t_wall", MAGENTA, 1'b1, NORMAL, pack4(0, 0, 0, 1), pack4(5, 6, 7, 6), 5'b00000, 0, 1'b0);
      checkOutput("t_wall const new_x", new_x, pack4(0, 1, 2, 1));
      checkOutput("t_wall const new_y", new_y, pack4(6, 6, 6, 5));
      checkOutput("t_wall const orient", new_orientation, ROT_LEFT);

      applyStimulus("t_fail", CYAN, 1'b0, ROT2, pack4(3, 4, 5, 6), pack4(10, 10, 10, 10), 5'b11111, 0, 1'b0);
      checkOutput("t_fail const new_x", new_x, pack4(3, 4, 5, 6));
      checkOutput("t_fail const orient", new_orientation, ROT2);

      applyStimulus("t_delay", MAGENTA, 1'b0, ROT_RIGHT, pack4(4, 5, 6, 5), pack4(1, 1, 1, 0), 5'b00000, 5, 1'b0);

      applyStimulus("t_kick2", CYAN, 1'b1, ROT_LEFT, pack4(3, 4, 5, 6), pack4(10, 10, 10, 10), 5'b00011, 2, 1'b0);

      applyStimulus("t_yellow", YELLOW, 1'b0, ROT2, pack4(4, 5, 4, 5), pack4(0, 0, 1, 1), 5'b00000, 0, 1'b0);

      doneBefore = doneCount;
      applyStimulus("t_busy", GREEN, 1'b0, NORMAL, pack4(3, 4, 5, 4), pack4(8, 8, 8, 9), 5'b00000, 3, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      checkOutput("t_busy done count", doneCount - doneBefore, 1);
      checkOutput("t_busy idle", busy, 1'b0);

      respDelay = 100000;
      queryIdx  = 0;
      @(negedge clk);
      block           = BLUE;
      rotate_left     = 1'b0;
      cur_orientation = NORMAL;
      x_block         = pack4(4, 5, 6, 5);
      y_block         = pack4(1, 1, 1, 0);
      start           = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      waited = 0;
      while (!query_valid && waited < 20) begin
         @(posedge clk);
         #1;
         waited++;
      end
      checkOutput("t_rst query_valid before", query_valid, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkResetValues("t_rst");
      doneBefore = doneCount;
      reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("t_rst no done", doneCount - doneBefore, 0);
      checkOutput("t_rst no response", queryIdx, 0);
      checkOutput("t_rst query_valid after", query_valid, 1'b0);

      applyStimulus("t_after", MAGENTA, 1'b0, NORMAL, pack4(4, 5, 6, 5), pack4(1, 1, 1, 0), 5'b00000, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
